// File: rtl/dbi_rx_decoder.sv
// dbi_rx_decoder
//   Receive-side Data Bus Inversion decoder. Restores the original data from
//   the wire data and its DBI flag, frames decoded beats into fixed-length
//   bursts and reports how many beats of each completed burst were inverted.
//
//   Flow control is valid/ready on both sides. The pipeline is one output
//   register backed by a one-entry skid buffer, so in_ready is a register and
//   never depends combinationally on out_ready.
//
// Parameters
//   WIDTH      data lane width in bits (even, >= 2)
//   BURST_LEN  beats per burst (>= 2)
//   CNT_W      width of the saturating per-burst inverted-beat counter
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        wire beat present
//   in_ready        decoder can accept a beat (registered, = ~skid_full)
//   in_data         data as driven on the wire
//   in_dbi          1 = transmitter inverted this beat
//   out_valid       decoded beat present
//   out_ready       consumer accepts beat
//   out_data        decoded data
//   out_last        current output beat is the final beat of its burst
//   burst_done      one-cycle pulse after the last beat handshakes
//   burst_inv_cnt   inverted beats in the most recently completed burst
//   dbi_err         (only with DBI_RX_CHECK_EN) one-cycle pulse when an
//                   accepted wire beat carried more than WIDTH/2 zeros
//
// Build option
//   DBI_RX_CHECK_EN  adds the dbi_err port and the wire zero-count checker.

module dbi_rx_decoder #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dbi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             burst_done,
  output logic [CNT_W-1:0] burst_inv_cnt
`ifdef DBI_RX_CHECK_EN
  ,
  output logic             dbi_err
`endif
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t             state;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]   run_cnt;
  logic [CNT_W-1:0]   run_next;

  logic               out_inv;
  logic               skid_full;
  logic [WIDTH-1:0]   skid_data;
  logic               skid_inv;

  logic               in_hs;
  logic               out_hs;
  logic               load_out;
  logic               last_beat;
  logic [WIDTH-1:0]   dec_data;

  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  // The output register can take a new beat when it is empty or being drained.
  assign load_out  = ~out_valid | out_ready;
  assign dec_data  = in_data ^ {WIDTH{in_dbi}};
  assign last_beat = (state == BURST) && (beat_cnt == BEAT_W'(BURST_LEN - 1));
  // Derived only from registers, so it cannot change while the beat is stalled.
  assign out_last  = out_valid & last_beat;

  // Saturating increment of the running inverted-beat count for the beat
  // currently leaving the output register.
  always_comb begin
    run_next = run_cnt;
    if (out_inv && (run_cnt != {CNT_W{1'b1}})) begin
      run_next = run_cnt + CNT_W'(1);
    end
  end

  // Output register and skid buffer. A skid entry always has priority over a
  // new beat, which keeps beat order; the skid is only filled when the output
  // register is stalled, and in_ready tracks the skid occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_inv   <= 1'b0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_inv  <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (load_out) begin
        if (skid_full) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          out_inv   <= skid_inv;
          skid_full <= 1'b0;
          in_ready  <= 1'b1;
        end else if (in_hs) begin
          out_valid <= 1'b1;
          out_data  <= dec_data;
          out_inv   <= in_dbi;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_hs) begin
        skid_data <= dec_data;
        skid_inv  <= in_dbi;
        skid_full <= 1'b1;
        in_ready  <= 1'b0;
      end
    end
  end

  // Burst framing FSM and per-burst statistics. Everything advances on output
  // handshakes only; the last-beat handshake publishes the count (including
  // that beat), clears the running count and returns to IDLE so the next
  // burst can start on the very next handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      run_cnt       <= '0;
      burst_done    <= 1'b0;
      burst_inv_cnt <= '0;
    end else begin
      burst_done <= 1'b0;
      if (out_hs) begin
        case (state)
          IDLE: begin
            state    <= BURST;
            beat_cnt <= BEAT_W'(1);
          end
          BURST: begin
            if (last_beat) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
          default: begin
            state    <= IDLE;
            beat_cnt <= '0;
          end
        endcase

        if (last_beat) begin
          burst_inv_cnt <= run_next;
          run_cnt       <= '0;
          burst_done    <= 1'b1;
        end else begin
          run_cnt <= run_next;
        end
      end
    end
  end

`ifdef DBI_RX_CHECK_EN
  localparam int ZW = $clog2(WIDTH + 1);

  logic [ZW-1:0] zero_cnt;

  // Number of zeros on the wire for the beat being offered.
  always_comb begin
    zero_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      zero_cnt = zero_cnt + ZW'(!in_data[i]);
    end
  end

  // Registered so the pulse lines up with the cycle the beat first sits in
  // the output register or the skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbi_err <= 1'b0;
    end else begin
      dbi_err <= in_hs && (zero_cnt > ZW'(WIDTH / 2));
    end
  end
`endif

endmodule

// File: tb/tb_dbi_rx_decoder.sv
// tb_dbi_rx_decoder
//   Self-checking bench for dbi_rx_decoder. Two instances share the same
//   stimulus: one with the default counter width and one with CNT_W=2 so the
//   saturating statistics can be observed. A queue-based reference model of
//   a two-deep FIFO (output register + skid) predicts every output.

module tb_dbi_rx_decoder;

  localparam int W  = 8;
  localparam int BL = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_dbi;
  logic         out_ready;

  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         burst_done;
  logic [3:0]   burst_inv_cnt;

  logic         sat_in_ready;
  logic         sat_out_valid;
  logic [W-1:0] sat_out_data;
  logic         sat_out_last;
  logic         sat_burst_done;
  logic [1:0]   sat_burst_inv_cnt;

`ifdef DBI_RX_CHECK_EN
  logic         dbi_err;
  logic         sat_dbi_err;
`endif

  dbi_rx_decoder #(.WIDTH(W), .BURST_LEN(BL), .CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_dbi        (in_dbi),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .burst_done    (burst_done),
    .burst_inv_cnt (burst_inv_cnt)
`ifdef DBI_RX_CHECK_EN
    ,
    .dbi_err       (dbi_err)
`endif
  );

  dbi_rx_decoder #(.WIDTH(W), .BURST_LEN(BL), .CNT_W(2)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (sat_in_ready),
    .in_data       (in_data),
    .in_dbi        (in_dbi),
    .out_valid     (sat_out_valid),
    .out_ready     (out_ready),
    .out_data      (sat_out_data),
    .out_last      (sat_out_last),
    .burst_done    (sat_burst_done),
    .burst_inv_cnt (sat_burst_inv_cnt)
`ifdef DBI_RX_CHECK_EN
    ,
    .dbi_err       (sat_dbi_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: beats held by the decoder, position in the burst,
  // inverted beats seen in the current burst and the expected statistics.
  logic [W:0] q[$];
  int         beat_idx;
  int         run_inv;
  logic [3:0] exp_inv4;
  logic [1:0] exp_inv2;
  bit         exp_done;
  bit         exp_err;
  bit         pending;

  int tests;
  int failures;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    beat_idx = 0;
    run_inv  = 0;
    exp_inv4 = '0;
    exp_inv2 = '0;
    exp_done = 0;
    exp_err  = 0;
    pending  = 0;
  endtask

  task automatic checkAll();
    checkOutput("out_valid", 32'(out_valid), 32'(q.size() > 0));
    checkOutput("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      checkOutput("out_data", 32'(out_data), 32'(q[0][W-1:0]));
      checkOutput("out_last", 32'(out_last), 32'(beat_idx == BL - 1));
    end else begin
      checkOutput("out_last_idle", 32'(out_last), 32'(0));
    end
    checkOutput("burst_done", 32'(burst_done), 32'(exp_done));
    checkOutput("inv_cnt", 32'(burst_inv_cnt), 32'(exp_inv4));
    checkOutput("sat_done", 32'(sat_burst_done), 32'(exp_done));
    checkOutput("sat_inv_cnt", 32'(sat_burst_inv_cnt), 32'(exp_inv2));
`ifdef DBI_RX_CHECK_EN
    checkOutput("dbi_err", 32'(dbi_err), 32'(exp_err));
`endif
  endtask

  // Advance one clock from a negedge: predict the effect of the coming edge
  // from the handshakes visible now, then check at the following negedge.
  task automatic cycle();
    bit         ih;
    bit         oh;
    logic [W:0] f;
    ih = in_valid & in_ready;
    oh = out_valid & out_ready;
    exp_done = 0;
    exp_err  = ih && ($countones(~in_data) > W / 2);
    if (oh && q.size() > 0) begin
      f = q.pop_front();
      run_inv += int'(f[W]);
      if (beat_idx == BL - 1) begin
        exp_inv4 = (run_inv > 15) ? 4'd15 : 4'(run_inv);
        exp_inv2 = (run_inv > 3) ? 2'd3 : 2'(run_inv);
        exp_done = 1;
        run_inv  = 0;
        beat_idx = 0;
      end else begin
        beat_idx++;
      end
    end
    if (ih) q.push_back({in_dbi, in_data ^ {W{in_dbi}}});
    pending = in_valid & ~ih;
    @(negedge clk);
    checkAll();
  endtask

  // A beat that was offered but not accepted is held, as a sender must.
  task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit dbi, input bit ordy);
    out_ready = ordy;
    if (!pending) begin
      in_valid = v;
      in_data  = d;
      in_dbi   = dbi;
    end
    cycle();
  endtask

  task automatic sendBeat(input logic [W-1:0] d, input bit dbi, input bit ordy);
    int n;
    n = 0;
    while (pending && n < 50) begin
      applyStimulus(1'b0, d, dbi, ordy);
      n++;
    end
    applyStimulus(1'b1, d, dbi, ordy);
    while (pending && n < 50) begin
      applyStimulus(1'b1, d, dbi, ordy);
      n++;
    end
    checkOutput("send_timeout", 32'(pending), 32'(0));
  endtask

  initial begin
    bit pat [BL];
    logic [W-1:0] sd [BL];
    tests    = 0;
    failures = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dbi    = 1'b0;
    out_ready = 1'b0;
    modelReset();

    // Reset values
    #3;
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_out_data", 32'(out_data), 32'(0));
    checkOutput("rst_out_last", 32'(out_last), 32'(0));
    checkOutput("rst_burst_done", 32'(burst_done), 32'(0));
    checkOutput("rst_inv_cnt", 32'(burst_inv_cnt), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'(1));

    // Basic decode, then close the burst
    sendBeat(8'hF0, 1'b0, 1'b1);
    checkOutput("dec_plain", 32'(out_data), 32'(8'hF0));
    sendBeat(8'h0F, 1'b1, 1'b1);
    checkOutput("dec_inv", 32'(out_data), 32'(8'hF0));
    for (int i = 0; i < BL - 2; i++) sendBeat(W'($urandom), 1'b0, 1'b1);

    // Back-to-back burst with DBI pattern 1,0,1,1,0,0,1,0
    pat = '{1, 0, 1, 1, 0, 0, 1, 0};
    for (int i = 0; i < BL; i++) sendBeat(W'($urandom), pat[i], 1'b1);
    checkOutput("pat_last", 32'(out_last), 32'(1));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("pat_done", 32'(burst_done), 32'(1));
    checkOutput("pat_inv_cnt", 32'(burst_inv_cnt), 32'(4));
    checkOutput("pat_sat_cnt", 32'(sat_burst_inv_cnt), 32'(3));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("done_one_cycle", 32'(burst_done), 32'(0));

    // All beats inverted: 8 in the wide counter, saturated 3 in the narrow one
    for (int i = 0; i < BL; i++) sendBeat(W'($urandom), 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("all_inv_cnt", 32'(burst_inv_cnt), 32'(8));
    checkOutput("all_sat_cnt", 32'(sat_burst_inv_cnt), 32'(3));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Stall for three cycles mid-burst with a sender still offering beats
    for (int i = 0; i < BL; i++) sd[i] = W'(8'h10 + i);
    for (int i = 0; i < 3; i++) sendBeat(sd[i], i[0], 1'b1);
    sendBeat(sd[3], 1'b1, 1'b0);
    checkOutput("stall_in_ready", 32'(in_ready), 32'(0));
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, sd[4], 1'b0, 1'b0);
      checkOutput("stall_hold_ready", 32'(in_ready), 32'(0));
      checkOutput("stall_out_data", 32'(out_data), 32'(sd[2]));
    end
    applyStimulus(1'b1, sd[4], 1'b0, 1'b1);
    for (int i = 5; i < BL; i++) sendBeat(sd[i], i[0], 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Reset after the fifth beat of a burst
    for (int i = 0; i < 5; i++) sendBeat(W'($urandom), 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'(0));
    checkOutput("mid_rst_last", 32'(out_last), 32'(0));
    checkOutput("mid_rst_data", 32'(out_data), 32'(0));
    checkOutput("mid_rst_inv_cnt", 32'(burst_inv_cnt), 32'(0));
    checkOutput("mid_rst_done", 32'(burst_done), 32'(0));
    in_valid = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkAll();
    for (int i = 0; i < BL; i++) begin
      sendBeat(W'($urandom), 1'b0, 1'b1);
      if (i < BL - 1) checkOutput("post_rst_not_last", 32'(out_last), 32'(0));
    end
    checkOutput("post_rst_last", 32'(out_last), 32'(1));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("post_rst_done", 32'(burst_done), 32'(1));

`ifdef DBI_RX_CHECK_EN
    // DC-rule checker: 7 wire zeros flags, exactly WIDTH/2 zeros does not
    sendBeat(8'h01, 1'b0, 1'b1);
    checkOutput("err_7_zeros", 32'(dbi_err), 32'(1));
    sendBeat(8'h0F, 1'b0, 1'b1);
    checkOutput("err_4_zeros", 32'(dbi_err), 32'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
`endif

    // Randomized traffic with random backpressure
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, W'($urandom), 1'($urandom),
                    $urandom_range(0, 3) != 0);
    end
    for (int n = 0; n < 10; n++) applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/dbi_rx_decoder.md
Name: dbi_rx_decoder

Overview:
- Receive-side Data Bus Inversion decoder. Counterpart of the transmit-side DBI-DC inversion decision logic.
- Takes wire data plus the DBI flag from the link, restores the original data, and frames beats into fixed-length bursts.
- Per-burst inversion statistics go to the link-training/monitor logic.
- Sits between the link PHY capture registers and the core-side consumer, with valid/ready flow control on both sides.

Parameters:
- WIDTH, 8, data lane width in bits. Must be even and ≥2.
- BURST_LEN, 8, beats per burst. Must be ≥2.
- CNT_W, 4, width of the per-burst inverted-beat counter (saturating).

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  wire beat present
- in_ready  output  1  decoder can accept a beat
- in_data  input  WIDTH  data as driven on the wire
- in_dbi  input  1  1 = transmitter inverted this beat
- out_valid  output  1  decoded beat present
- out_ready  input  1  consumer accepts beat
- out_data  output  WIDTH  decoded data (in_data XOR {WIDTH{in_dbi}})
- out_last  output  1  beat is the final beat of the burst
- burst_done  output  1  one-cycle pulse after the last beat handshakes
- burst_inv_cnt  output  CNT_W  inverted beats in the most recently completed burst

Behaviour:
- Reset (async assert, sync-released on clk): out_valid=0, out_data=0, out_last=0, in_ready=1 after release, burst_done=0, burst_inv_cnt=0, skid empty, beat counter=0, FSM=IDLE. Reset mid-burst discards all buffered beats and partial statistics.
- Decode: out_data = in_data XOR replicate(in_dbi). Decoding is registered at acceptance (input handshake = in_valid & in_ready).
- Pipeline: one output register plus a one-entry skid buffer.
  - Latency: an accepted beat appears on out_valid the next cycle when the output register is empty or draining.
  - in_ready = ~skid_full, registered. No combinational path from out_ready to in_ready.
- Skid handling:
  - Output register holds and out_ready=0 while a beat is accepted → the beat goes to the skid; in_ready drops next cycle.
  - Output handshake with the skid full → the skid moves to the output register; in_ready rises next cycle.
  - Simultaneous input and output handshake with the skid empty → the output register reloads directly; no bubble.
- out_data, out_last and the per-beat flag stay stable while out_valid=1 and out_ready=0.
- FSM: IDLE → BURST on the first output handshake. In BURST, the beat counter increments on each output handshake.
  - out_last = 1 when the beat counter = BURST_LEN-1.
  - The handshake of the last beat → IDLE, beat counter = 0.
  - Back-to-back bursts are allowed with no idle cycle.
- Statistics:
  - A running counter increments on each output handshake whose beat was inverted. It saturates at 2^CNT_W-1 and never wraps.
  - On the last-beat handshake, burst_inv_cnt loads the final count including that beat, and the running counter clears.
  - burst_done pulses for exactly one cycle, the cycle after the last-beat handshake.
  - burst_inv_cnt holds its value until the next burst completes.
- in_valid=1 with in_ready=0: the beat is not accepted. The sender must hold it.

Optional Feature:
- Macro: DBI_RX_CHECK_EN.
- When defined: adds output port dbi_err (1 bit, reset 0).
  - On each input handshake, count zeros in in_data (wire data). If the count > WIDTH/2, dbi_err pulses high for one cycle, aligned with the cycle the beat first appears in the output register or skid.
  - Such a beat violates the DC rule: the transmitter must keep wire zeros ≤ WIDTH/2.
  - Decoding is unaffected.
- When undefined: no dbi_err port and no zero-count logic. Behaviour is otherwise identical.

Test Plan:
- Reset, then in_data=8'hF0, in_dbi=0 → out_data=8'hF0 one cycle later. Then in_data=8'h0F, in_dbi=1 → out_data=8'hF0.
- Stream 8 beats with out_ready=1, in_dbi pattern 1,0,1,1,0,0,1,0 → out_last on beat 8 only, burst_done pulse next cycle, burst_inv_cnt=4. A second burst immediately follows with no gap.
- Hold out_ready=0 for 3 cycles mid-burst with in_valid=1 → exactly one beat is captured in the skid, in_ready=0, out_data stable. Release → no beat lost or duplicated; order preserved.
- CNT_W=2, 8-beat burst with all in_dbi=1 → burst_inv_cnt=3 (saturated).
- Assert rst_n=0 after beat 5 of a burst → outputs return to reset values immediately. A following 8-beat burst produces out_last on its own 8th beat.
- With DBI_RX_CHECK_EN defined: in_data=8'h01 (7 zeros) → dbi_err pulses once. in_data=8'h0F (4 zeros) → dbi_err stays 0.
